rotate_buf_wr_ctrl: RTL and testbench

//  Write-side controller for the 4096x16 / 256x256 rotate frame buffer. Accepts an RGB565

---
 rtl/rotate_buf_pkg.sv | 17 +
 rtl/rotate_wr_addr_gen.sv | 25 ++
 rtl/rotate_buf_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_rotate_buf_wr_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_buf_pkg.sv
// Shared geometry and types for the 4096x16 / 256x256 rotate frame buffer.
package rotate_buf_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TILE_W    = 128;
  localparam int unsigned TILE_H    = 16;
  localparam int unsigned COL_W     = $clog2(TILE_W);
  localparam int unsigned ROW_W     = $clog2(TILE_H);
  localparam int unsigned ADDR_W    = 1 + COL_W + ROW_W;
  localparam int unsigned RD_ADDR_W = 1 + COL_W;

  typedef enum logic {
    ROT_CW  = 1'b0,
    ROT_CCW = 1'b1
  } rot_dir_t;

endpackage

// File: rtl/rotate_wr_addr_gen.sv
// Transposed write-address mapping: one 256-bit read word holds one rotated output line.
module rotate_wr_addr_gen
  import rotate_buf_pkg::*;
(
  input  logic             bank,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  rot_dir_t         dir,
  output logic [ADDR_W-1:0] addr_c
);

  logic [COL_W-1:0] col_a;
  logic [ROW_W-1:0] row_a;

  always_comb begin
    col_a = col;
    row_a = ROW_W'(TILE_H - 1) - row;
    if (dir == ROT_CCW) begin
      col_a = COL_W'(TILE_W - 1) - col;
      row_a = row;
    end
    addr_c = {bank, col_a, row_a};
  end

endmodule

// File: rtl/rotate_buf_wr_ctrl.sv
// Write-side ping-pong tiler for the rotate frame buffer.
// Optional counter-clockwise mapping via `ROTATE_CCW_EN (adds rot_ccw input).
module rotate_buf_wr_ctrl
  import rotate_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_sof,
  input  logic              pix_vld,
  input  logic [DATA_W-1:0] pix_data,
`ifdef ROTATE_CCW_EN
  input  logic              rot_ccw,
`endif
  output logic              pix_rdy,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              tile_vld,
  output logic              tile_bank,
  input  logic              tile_done,
  input  logic              tile_done_bk,
  output logic [15:0]       tile_cnt
);

  logic             wr_bank, wr_bank_nxt;
  logic [ROW_W-1:0] row, row_nxt, row_eff;
  logic [COL_W-1:0] col, col_nxt, col_eff;
  logic [1:0]       bank_busy, busy_nxt;
  logic             beat, last;
  logic             done_d1, bank_d1;
  rot_dir_t         dir_eff;
  logic [ADDR_W-1:0] addr_c;

  // Counter advance, bank flags and reader handshake; sof restarts the tile in place.
  always_comb begin
    beat        = pix_vld & pix_rdy;
    row_eff     = pix_sof ? '0 : row;
    col_eff     = pix_sof ? '0 : col;
    last        = (row_eff == ROW_W'(TILE_H - 1)) && (col_eff == COL_W'(TILE_W - 1));
    row_nxt     = row;
    col_nxt     = col;
    wr_bank_nxt = wr_bank;
    busy_nxt    = bank_busy;
    if (tile_done) busy_nxt[tile_done_bk] = 1'b0;
    if (beat) begin
      if (last) begin
        row_nxt             = '0;
        col_nxt             = '0;
        wr_bank_nxt         = ~wr_bank;
        busy_nxt[wr_bank]   = 1'b1;
      end else if (col_eff == COL_W'(TILE_W - 1)) begin
        col_nxt = '0;
        row_nxt = row_eff + ROW_W'(1);
      end else begin
        col_nxt = col_eff + COL_W'(1);
        row_nxt = row_eff;
      end
    end
  end

`ifdef ROTATE_CCW_EN
  rot_dir_t tile_dir, tile_dir_nxt;

  // Direction is latched on the first pixel of a tile and held for the rest of it.
  always_comb begin
    dir_eff      = tile_dir;
    tile_dir_nxt = tile_dir;
    if (beat && (row_eff == '0) && (col_eff == '0)) begin
      dir_eff      = rot_ccw ? ROT_CCW : ROT_CW;
      tile_dir_nxt = dir_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tile_dir <= ROT_CW;
    else        tile_dir <= tile_dir_nxt;
  end
`else
  assign dir_eff = ROT_CW;
`endif

  rotate_wr_addr_gen u_addr_gen (
    .bank   (wr_bank),
    .row    (row_eff),
    .col    (col_eff),
    .dir    (dir_eff),
    .addr_c (addr_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      row         <= '0;
      col         <= '0;
      bank_busy   <= 2'b00;
      pix_rdy     <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      done_d1     <= 1'b0;
      bank_d1     <= 1'b0;
      tile_vld    <= 1'b0;
      tile_bank   <= 1'b0;
      tile_cnt    <= 16'd0;
    end else begin
      wr_bank   <= wr_bank_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      bank_busy <= busy_nxt;
      pix_rdy   <= ~busy_nxt[wr_bank_nxt];
      buf_wr_en <= beat;
      if (beat) begin
        buf_wr_addr <= addr_c;
        buf_wr_data <= pix_data;
      end
      // Tile announcement trails the final write by one cycle.
      done_d1  <= beat & last;
      bank_d1  <= wr_bank;
      tile_vld <= done_d1;
      if (done_d1) begin
        tile_bank <= bank_d1;
        tile_cnt  <= tile_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rotate_buf_wr_ctrl.sv
// Randomized bench for rotate_buf_wr_ctrl against a pixel-index reference model.
module tb_rotate_buf_wr_ctrl;
  import rotate_buf_pkg::*;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_rec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        bank;
    logic [15:0] cnt;
  } tile_rec_t;

  localparam int TILE_PIX = int'(TILE_W * TILE_H);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pix_sof = 1'b0;
  logic              pix_vld = 1'b0;
  logic [DATA_W-1:0] pix_data = '0;
`ifdef ROTATE_CCW_EN
  logic              rot_ccw = 1'b0;
`endif
  logic              pix_rdy;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;
  logic              tile_vld;
  logic              tile_bank;
  logic              tile_done = 1'b0;
  logic              tile_done_bk = 1'b0;
  logic [15:0]       tile_cnt;

  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  wr_rec_t   exp_wr[$], act_wr[$];
  tile_rec_t exp_tl[$], act_tl[$];

  // Reference model state: position of the next pixel inside the current tile.
  logic [1:0]  m_busy;
  logic        m_bank;
  int          m_pos;
  logic [15:0] m_cnt;
  logic        m_ccw;
  logic        m_run;

  rotate_buf_wr_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_sof      (pix_sof),
    .pix_vld      (pix_vld),
    .pix_data     (pix_data),
`ifdef ROTATE_CCW_EN
    .rot_ccw      (rot_ccw),
`endif
    .pix_rdy      (pix_rdy),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .buf_wr_data  (buf_wr_data),
    .tile_vld     (tile_vld),
    .tile_bank    (tile_bank),
    .tile_done    (tile_done),
    .tile_done_bk (tile_done_bk),
    .tile_cnt     (tile_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) act_wr.push_back(wr_rec_t'{cyc: cyc, addr: buf_wr_addr, data: buf_wr_data});
    if (tile_vld === 1'b1) act_tl.push_back(tile_rec_t'{cyc: cyc, bank: tile_bank, cnt: tile_cnt});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic wr_rec_t qwr(input wr_rec_t q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : '0;
  endfunction

  function automatic tile_rec_t qtl(input tile_rec_t q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : '0;
  endfunction

  function automatic int wr_diff();
    for (int i = 0; i < exp_wr.size(); i++)
      if (i >= act_wr.size() || act_wr[i] !== exp_wr[i]) return i;
    return (act_wr.size() != exp_wr.size()) ? exp_wr.size() : -1;
  endfunction

  function automatic int tl_diff();
    for (int i = 0; i < exp_tl.size(); i++)
      if (i >= act_tl.size() || act_tl[i] !== exp_tl[i]) return i;
    return (act_tl.size() != exp_tl.size()) ? exp_tl.size() : -1;
  endfunction

  // One clock of stimulus; the model predicts the write and tile announcement it should cause.
  task automatic drive_cycle(input logic vld, input logic sof, input logic [DATA_W-1:0] data,
                             input logic done, input logic done_bk);
    logic acc;
    int r, c, a;
    pix_vld = vld; pix_sof = sof; pix_data = data; tile_done = done; tile_done_bk = done_bk;
    acc = vld && m_run && !m_busy[m_bank];
    if (done) m_busy[done_bk] = 1'b0;
    if (acc) begin
      if (sof) m_pos = 0;
`ifdef ROTATE_CCW_EN
      if (m_pos == 0) m_ccw = rot_ccw;
`endif
      r = m_pos / int'(TILE_W);
      c = m_pos % int'(TILE_W);
      if (m_ccw) a = (int'(TILE_W) - 1 - c) * int'(TILE_H) + r;
      else       a = c * int'(TILE_H) + (int'(TILE_H) - 1 - r);
      if (m_bank) a += TILE_PIX;
      exp_wr.push_back(wr_rec_t'{cyc: cyc + 1, addr: ADDR_W'(a), data: data});
      m_pos++;
      if (m_pos == TILE_PIX) begin
        m_busy[m_bank] = 1'b1;
        m_cnt++;
        exp_tl.push_back(tile_rec_t'{cyc: cyc + 2, bank: m_bank, cnt: m_cnt});
        m_bank = ~m_bank;
        m_pos  = 0;
      end
    end
    @(posedge clk); #1;
    pix_vld = 1'b0; pix_sof = 1'b0; tile_done = 1'b0;
  endtask

  task automatic drain();
    repeat (4) drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_vld = 1'b0; pix_sof = 1'b0; tile_done = 1'b0; tile_done_bk = 1'b0; pix_data = '0;
    m_busy = 2'b00; m_bank = 1'b0; m_pos = 0; m_cnt = 16'd0; m_ccw = 1'b0; m_run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_wr.delete(); act_wr.delete(); exp_tl.delete(); act_tl.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_run = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    pix_vld = 1'b1; pix_data = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({pix_rdy, buf_wr_en, buf_wr_addr, buf_wr_data, tile_vld, tile_bank, tile_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b en=%b addr=%h data=%h vld=%b bank=%b cnt=%h, expected all 0",
               pix_rdy, buf_wr_en, buf_wr_addr, buf_wr_data, tile_vld, tile_bank, tile_cnt);
    end
    do_reset();
    vectors++;
    if (pix_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_rdy_after_release: got %b expected 1", pix_rdy);
    end
  endtask

  task automatic test_full_tile();
    int d;
    do_reset();
    for (int k = 0; k < TILE_PIX; k++) drive_cycle(1'b1, 1'b0, DATA_W'(k), 1'b0, 1'b0);
    drain();
    d = wr_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL full_tile_writes: rec %0d got %h expected %h (count %0d vs %0d)",
               d, qwr(act_wr, d), qwr(exp_wr, d), act_wr.size(), exp_wr.size());
    end
    vectors++;
    if (qwr(act_wr, 0).addr !== 12'h00F || qwr(act_wr, 0).data !== 16'd0) begin
      miscompares++;
      $display("FAIL full_tile_first_pixel: got addr %h data %h expected 00f 0000",
               qwr(act_wr, 0).addr, qwr(act_wr, 0).data);
    end
    vectors++;
    if (qwr(act_wr, TILE_PIX - 1).addr !== 12'h7F0) begin
      miscompares++;
      $display("FAIL full_tile_last_pixel: got addr %h expected 7f0", qwr(act_wr, TILE_PIX - 1).addr);
    end
    vectors++;
    if (act_tl.size() != 1 || qtl(act_tl, 0).bank !== 1'b0 || qtl(act_tl, 0).cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL full_tile_vld: got %0d pulses, bank %b cnt %0d, expected 1 pulse bank 0 cnt 1",
               act_tl.size(), qtl(act_tl, 0).bank, qtl(act_tl, 0).cnt);
    end
    d = tl_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL full_tile_timing: rec %0d got %h expected %h", d, qtl(act_tl, d), qtl(exp_tl, d));
    end
  endtask

  task automatic test_backpressure();
    int d;
    do_reset();
    for (int k = 0; k < 20000 && m_cnt < 16'd2; k++)
      drive_cycle($urandom_range(0, 3) != 0, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    vectors++;
    if (pix_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_stall: got pix_rdy %b expected 0", pix_rdy);
    end
    repeat (3) drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    vectors++;
    if (pix_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_hold: got pix_rdy %b expected 0", pix_rdy);
    end
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (pix_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release: got pix_rdy %b expected 1", pix_rdy);
    end
    drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drain();
    vectors++;
    if (qwr(act_wr, act_wr.size() - 1).addr !== 12'h00F) begin
      miscompares++;
      $display("FAIL backpressure_resume_addr: got %h expected 00f", qwr(act_wr, act_wr.size() - 1).addr);
    end
    d = wr_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL backpressure_writes: rec %0d got %h expected %h (count %0d vs %0d)",
               d, qwr(act_wr, d), qwr(exp_wr, d), act_wr.size(), exp_wr.size());
    end
    d = tl_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL backpressure_tiles: rec %0d got %h expected %h", d, qtl(act_tl, d), qtl(exp_tl, d));
    end
  endtask

  task automatic test_sof();
    int d;
    do_reset();
    for (int k = 0; k < 1000; k++) drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 10000 && m_cnt < 16'd1; k++)
      drive_cycle($urandom_range(0, 4) != 0, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drain();
    vectors++;
    if (qwr(act_wr, 1000).addr !== 12'h00F) begin
      miscompares++;
      $display("FAIL sof_restart_addr: got %h expected 00f", qwr(act_wr, 1000).addr);
    end
    vectors++;
    if (act_tl.size() != 1 || qtl(act_tl, 0).bank !== 1'b0 || qtl(act_tl, 0).cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL sof_tile_vld: got %0d pulses, bank %b cnt %0d, expected 1 pulse bank 0 cnt 1",
               act_tl.size(), qtl(act_tl, 0).bank, qtl(act_tl, 0).cnt);
    end
    d = wr_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL sof_writes: rec %0d got %h expected %h (count %0d vs %0d)",
               d, qwr(act_wr, d), qwr(exp_wr, d), act_wr.size(), exp_wr.size());
    end
  endtask

  task automatic test_done_collision();
    int d;
    do_reset();
    for (int k = 0; k < 10000 && m_cnt < 16'd2; k++)
      drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5000 && m_pos != TILE_PIX - 1; k++)
      drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b1, 1'b1);
    vectors++;
    if (pix_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_rdy: got pix_rdy %b expected 1", pix_rdy);
    end
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (pix_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL spurious_done_rdy: got pix_rdy %b expected 1", pix_rdy);
    end
    for (int k = 0; k < 10000 && m_cnt < 16'd4; k++)
      drive_cycle($urandom_range(0, 3) != 0, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    vectors++;
    if (pix_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_bank0_still_busy: got pix_rdy %b expected 0", pix_rdy);
    end
    drain();
    d = tl_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL collision_tiles: rec %0d got %h expected %h", d, qtl(act_tl, d), qtl(exp_tl, d));
    end
    d = wr_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL collision_writes: rec %0d got %h expected %h (count %0d vs %0d)",
               d, qwr(act_wr, d), qwr(exp_wr, d), act_wr.size(), exp_wr.size());
    end
  endtask

`ifdef ROTATE_CCW_EN
  task automatic test_ccw();
    int d;
    do_reset();
    rot_ccw = 1'b1;
    drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 10000 && m_cnt < 16'd1; k++) begin
      rot_ccw = 1'($urandom);
      drive_cycle($urandom_range(0, 3) != 0, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    end
    rot_ccw = 1'b0;
    repeat (3) drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drain();
    vectors++;
    if (qwr(act_wr, 0).addr !== 12'h7F0 || qwr(act_wr, TILE_PIX - 1).addr !== 12'h00F) begin
      miscompares++;
      $display("FAIL ccw_corners: got first %h last %h expected 7f0 00f",
               qwr(act_wr, 0).addr, qwr(act_wr, TILE_PIX - 1).addr);
    end
    vectors++;
    if (qwr(act_wr, TILE_PIX).addr !== 12'h80F) begin
      miscompares++;
      $display("FAIL ccw_next_tile_cw: got %h expected 80f", qwr(act_wr, TILE_PIX).addr);
    end
    d = wr_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL ccw_writes: rec %0d got %h expected %h (count %0d vs %0d)",
               d, qwr(act_wr, d), qwr(exp_wr, d), act_wr.size(), exp_wr.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    int d;
    do_reset();
    for (int k = 0; k < TILE_PIX; k++) drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 500; k++) drive_cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    vectors++;
    if (buf_wr_en !== 1'b1 || tile_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_reset_precondition: got en=%b cnt=%0d expected en=1 cnt=1", buf_wr_en, tile_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pix_rdy, buf_wr_en, buf_wr_addr, buf_wr_data, tile_vld, tile_bank, tile_cnt} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got rdy=%b en=%b addr=%h data=%h vld=%b bank=%b cnt=%h, expected all 0",
               pix_rdy, buf_wr_en, buf_wr_addr, buf_wr_data, tile_vld, tile_bank, tile_cnt);
    end
    do_reset();
    for (int k = 0; k < 10000 && m_cnt < 16'd1; k++)
      drive_cycle($urandom_range(0, 3) != 0, 1'b0, DATA_W'($urandom), 1'b0, 1'b0);
    drain();
    vectors++;
    if (act_tl.size() != 1 || qtl(act_tl, 0).bank !== 1'b0 || qtl(act_tl, 0).cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_reset_tile: got %0d pulses, bank %b cnt %0d, expected 1 pulse bank 0 cnt 1",
               act_tl.size(), qtl(act_tl, 0).bank, qtl(act_tl, 0).cnt);
    end
    d = wr_diff(); vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL mid_reset_writes: rec %0d got %h expected %h (count %0d vs %0d)",
               d, qwr(act_wr, d), qwr(exp_wr, d), act_wr.size(), exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_backpressure();
    test_sof();
    test_done_collision();
`ifdef ROTATE_CCW_EN
    test_ccw();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
